mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the MIPS datapath. Sequences one instruction over 3-5 cycles by driving
//  the datapath's mux selects, write enables and ALUOp. Includes ALUSrcB, whose select picks among

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mem_wait_timer.sv | 16 +
 rtl/mips_multicycle_ctrl.sv | 146 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, controller state encoding and datapath select encodings shared by control and datapath
package mips_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd12
  } state_t;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_EXT   = 2'b10;
  localparam logic [1:0] SRCB_EXTSH = 2'b11;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;
  function automatic logic is_mem_state(state_t s);
    return s inside {S_FETCH, S_MEMRD, S_MEMWR};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating count of memory wait cycles, flags when the timeout value is reached
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 8
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam logic [TMR_W-1:0] MAX = TMR_W'(MEM_TIMEOUT);
  logic [TMR_W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= i_clr ? '0 : (i_en && r_cnt != MAX) ? r_cnt + TMR_W'(1) : r_cnt;
  assign o_expired = r_cnt == MAX;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM with memory handshake, illegal-opcode and timeout flags
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal,
  output logic       fault,
  output logic [3:0] state
);
  state_t r_state, w_next;
  logic   r_run, r_illegal, r_fault;
  logic   w_bad_op, w_wait, w_expired, w_clr, w_unused;
  ctrl_t  w_c;
  // Zero only matters to the datapath's PCWriteCond gate
  assign w_unused = Zero;
  assign w_bad_op = !(Opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
  assign w_wait   = r_run && !mem_ready && is_mem_state(r_state);
  assign w_clr    = !rst_n || w_next != r_state;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W)) u_timer (
    .clk       (clk),
    .i_clr     (w_clr),
    .i_en      (w_wait),
    .o_expired (w_expired)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_run     <= 1'b0;
      r_illegal <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_run     <= 1'b1;
      r_illegal <= r_state == S_DECODE && w_bad_op;
      r_fault   <= r_fault || w_next == S_FAULT;
    end
  // r_run is low for the first cycle after reset so outputs stay quiet until release
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (Opcode == OP_LW || Opcode == OP_SW) ? S_MEMADR :
                         (Opcode == OP_R)    ? S_EXEC   :
                         (Opcode == OP_BEQ)  ? S_BRANCH :
                         (Opcode == OP_ADDI) ? S_ADDIEX :
                         (Opcode == OP_J)    ? S_JUMP   : S_FETCH;
      S_MEMADR: w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FETCH;
    endcase
    if (w_wait && w_expired) w_next = S_FAULT;
    if (!r_run) w_next = S_FETCH;
  end
  always_comb begin
    w_c = '0;
    if (r_run)
      case (r_state)
        S_FETCH: begin
          w_c.mem_read  = 1'b1;
          w_c.alu_src_b = SRCB_FOUR;
          w_c.alu_op    = ALUOP_ADD;
          w_c.pc_src    = PCSRC_ALU;
          w_c.ir_write  = mem_ready;
          w_c.pc_write  = mem_ready;
        end
        S_DECODE: w_c.alu_src_b = SRCB_EXTSH;
        S_MEMADR, S_ADDIEX: begin
          w_c.alu_src_a = 1'b1;
          w_c.alu_src_b = SRCB_EXT;
        end
        S_MEMRD: begin
          w_c.mem_read = 1'b1;
          w_c.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          w_c.reg_write  = 1'b1;
          w_c.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          w_c.mem_write = 1'b1;
          w_c.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          w_c.alu_src_a = 1'b1;
          w_c.alu_src_b = SRCB_RD2;
          w_c.alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          w_c.reg_write = 1'b1;
          w_c.reg_dst   = 1'b1;
        end
        S_ADDIWB: w_c.reg_write = 1'b1;
        S_BRANCH: begin
          w_c.alu_src_a     = 1'b1;
          w_c.alu_op        = ALUOP_SUB;
          w_c.pc_src        = PCSRC_ALUOUT;
          w_c.pc_write_cond = 1'b1;
        end
        S_JUMP: begin
          w_c.pc_src   = PCSRC_JUMP;
          w_c.pc_write = 1'b1;
        end
        default: ;
      endcase
  end
  assign PCWrite     = w_c.pc_write;
  assign PCWriteCond = w_c.pc_write_cond;
  assign IorD        = w_c.i_or_d;
  assign MemRead     = w_c.mem_read;
  assign MemWrite    = w_c.mem_write;
  assign IRWrite     = w_c.ir_write;
  assign MemtoReg    = w_c.mem_to_reg;
  assign RegDst      = w_c.reg_dst;
  assign RegWrite    = w_c.reg_write;
  assign ALUSrcA     = w_c.alu_src_a;
  assign ALUSrcB     = w_c.alu_src_b;
  assign ALUOp       = w_c.alu_op;
  assign PCSrc       = w_c.pc_src;
  assign illegal     = r_illegal;
  assign fault       = r_fault;
  assign state       = r_state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: per-cycle vector table for every instruction class plus a timeout/fault sequence
module tb_mips_multicycle_ctrl;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, ILL = 6'b111111;
  localparam logic [9:0] Z    = 10'b0000000000;
  localparam logic [9:0] FR   = 10'b0001000000;
  localparam logic [9:0] FG   = 10'b1001010000;
  localparam logic [9:0] A1   = 10'b0000000001;
  localparam logic [9:0] AWB  = 10'b0000000110;
  localparam logic [9:0] MRD  = 10'b0011000000;
  localparam logic [9:0] MWB  = 10'b0000001010;
  localparam logic [9:0] BR   = 10'b0100000001;
  localparam logic [9:0] JP   = 10'b1000000000;
  localparam logic [9:0] AIWB = 10'b0000000010;
  localparam logic [9:0] MWR  = 10'b0010100000;
  logic clk = 0, rst_n = 0, Zero = 1, mem_ready = 0;
  logic [5:0] Opcode = '0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic illegal, fault;
  logic [3:0] state;
  logic [9:0] strb;
  int errs = 0, checks = 0;
  typedef struct {
    logic rst_n; logic [5:0] op; logic rdy; logic [3:0] st; logic [9:0] strb;
    logic [1:0] srcb, aluop, pcsrc; logic ill, flt;
  } vec_t;
  vec_t v[$];
  mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .TMR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .illegal(illegal), .fault(fault), .state(state)
  );
  assign strb = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA};
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic [9:0] s, input logic [1:0] srcb, input logic [1:0] aluop,
                     input logic [1:0] pcsrc, input logic ill, input logic flt);
    v.push_back('{r, op, rdy, st, s, srcb, aluop, pcsrc, ill, flt});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    add(0, R, 1, 0, Z, 0, 0, 0, 0, 0);
    add(1, R, 0, 0, Z, 0, 0, 0, 0, 0);
    add(1, R, 0, 0, FR, 1, 0, 0, 0, 0);
    add(1, R, 1, 0, FG, 1, 0, 0, 0, 0);
    add(1, R, 1, 1, Z, 3, 0, 0, 0, 0);
    add(1, R, 1, 6, A1, 0, 2, 0, 0, 0);
    add(1, R, 1, 7, AWB, 0, 0, 0, 0, 0);
    add(1, LW, 1, 0, FG, 1, 0, 0, 0, 0);
    add(1, LW, 1, 1, Z, 3, 0, 0, 0, 0);
    add(1, LW, 0, 2, A1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, LW, 0, 3, MRD, 0, 0, 0, 0, 0);
    add(1, LW, 1, 3, MRD, 0, 0, 0, 0, 0);
    add(1, LW, 1, 4, MWB, 0, 0, 0, 0, 0);
    add(1, BEQ, 1, 0, FG, 1, 0, 0, 0, 0);
    add(1, BEQ, 1, 1, Z, 3, 0, 0, 0, 0);
    add(1, BEQ, 1, 10, BR, 0, 1, 1, 0, 0);
    add(1, ILL, 1, 0, FG, 1, 0, 0, 0, 0);
    add(1, ILL, 1, 1, Z, 3, 0, 0, 0, 0);
    add(1, ILL, 0, 0, FR, 1, 0, 0, 1, 0);
    add(1, ILL, 0, 0, FR, 1, 0, 0, 0, 0);
    add(1, J, 1, 0, FG, 1, 0, 0, 0, 0);
    add(1, J, 1, 1, Z, 3, 0, 0, 0, 0);
    add(1, J, 1, 11, JP, 0, 0, 2, 0, 0);
    add(1, ADDI, 1, 0, FG, 1, 0, 0, 0, 0);
    add(1, ADDI, 1, 1, Z, 3, 0, 0, 0, 0);
    add(1, ADDI, 1, 8, A1, 2, 0, 0, 0, 0);
    add(1, ADDI, 1, 9, AIWB, 0, 0, 0, 0, 0);
    add(1, SW, 1, 0, FG, 1, 0, 0, 0, 0);
    add(1, SW, 1, 1, Z, 3, 0, 0, 0, 0);
    add(1, SW, 0, 2, A1, 2, 0, 0, 0, 0);
    add(1, SW, 0, 5, MWR, 0, 0, 0, 0, 0);
    add(0, SW, 0, 5, MWR, 0, 0, 0, 0, 0);
    add(1, SW, 0, 0, Z, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, SW, 0, 0, FR, 1, 0, 0, 0, 0);
    add(1, SW, 1, 0, FG, 1, 0, 0, 0, 0);
    add(1, SW, 1, 1, Z, 3, 0, 0, 0, 0);
    add(1, SW, 1, 2, A1, 2, 0, 0, 0, 0);
    rst_n = 0;
    tick();
    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rst_n;
      Opcode = v[i].op;
      mem_ready = v[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d state", i), state, v[i].st);
      chk($sformatf("v%0d strobes", i), strb, v[i].strb);
      chk($sformatf("v%0d ALUSrcB", i), ALUSrcB, v[i].srcb);
      chk($sformatf("v%0d ALUOp", i), ALUOp, v[i].aluop);
      chk($sformatf("v%0d PCSrc", i), PCSrc, v[i].pcsrc);
      chk($sformatf("v%0d illegal", i), illegal, v[i].ill);
      chk($sformatf("v%0d fault", i), fault, v[i].flt);
      chk($sformatf("v%0d rd&wr", i), MemRead & MemWrite, 0);
      chk($sformatf("v%0d regw&pcw", i), RegWrite & PCWrite, 0);
      tick();
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    Opcode = SW;
    mem_ready = 1;
    n = 0;
    while (state != 4'd5 && n < 10) begin
      tick();
      n++;
    end
    chk("reach MEMWR", state, 5);
    mem_ready = 0;
    n = 0;
    while (state == 4'd5 && n < 20) begin
      chk($sformatf("MEMWR wait %0d MemWrite", n), MemWrite, 1);
      n++;
      tick();
    end
    chk("MEMWR cycles before fault", n, 5);
    chk("fault state", state, 12);
    chk("fault flag", fault, 1);
    chk("fault strobes", strb, Z);
    mem_ready = 1;
    Opcode = R;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fault sticky %0d state", i), state, 12);
      chk($sformatf("fault sticky %0d flag", i), fault, 1);
      chk($sformatf("fault sticky %0d strobes", i), strb, Z);
    end
    rst_n = 0;
    tick();
    chk("reset clears fault", fault, 0);
    chk("reset state", state, 0);
    chk("reset strobes", strb, Z);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
